vec_lsu_sequencer: RTL and testbench
====================================

Name: vec_lsu_sequencer

Overview:
Element-by-element sequencer for vector load/store.
- Started by the decode controller on a load or store instruction.
- Walks elements 0..vl-1 and generates one memory request per element: unit-stride, constant-stride or indexed address.
- Runs a valid/ready request handshake to the data memory, steers load data into the vector register file and store data out of it.
- Raises `busy` while running and pulses `done` at completion.

Parameters:
- XLEN, 32, scalar/address/memory data width
- VL_W, 9, width of vl and of the element index
- IDX_W, 32, width of an index-vector offset element

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle launch pulse; accepted only in IDLE
- ld_inst  in  1  load instruction, sampled at start
- st_inst  in  1  store instruction, sampled at start
- stride_sel  in  1  1 = unit stride, 0 = constant stride; sampled at start
- index_str  in  1  indexed access; overrides stride_sel; sampled at start
- eew  in  2  element width, sampled at start: 00 = 8b, 01 = 16b, 10 = 32b, 11 = reserved (treated as 32b)
- base_addr  in  XLEN  rs1 base, sampled at start
- stride  in  XLEN  rs2 byte stride, sampled at start
- vl  in  VL_W  element count, sampled at start
- idx_offset  in  IDX_W  offset element for current elem_idx (combinational from register file)
- vs_rdata  in  XLEN  store element for current elem_idx (combinational)
- elem_idx  out  VL_W  current element index
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  XLEN  byte address
- mem_we  out  1  1 = store
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  store data
- mem_rsp_valid  in  1  load response valid
- mem_rdata  in  XLEN  load response data
- vd_wr_en  out  1  write load element to vector register file
- vd_wdata  out  XLEN  load element, zero-extended
- busy  out  1  sequencer not IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; elem_idx 0; address register 0.
- States are IDLE, ISSUE, WAIT_RSP and DONE.
- IDLE:
  - start with vl != 0 latches all config and sets addr = base_addr (indexed: base_addr + idx_offset of element 0), elem_idx = 0, then goes to ISSUE.
  - start with vl == 0 goes to DONE; no requests are issued.
  - start with neither ld_inst nor st_inst set is ignored.
- ISSUE:
  - mem_req_valid = 1; mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_req_ready.
  - On handshake, load: go to WAIT_RSP.
  - On handshake, store: advance; if this was the last element (elem_idx == vl-1) go to DONE, else stay in ISSUE.
- WAIT_RSP:
  - mem_req_valid = 0.
  - On mem_rsp_valid: vd_wr_en = 1 for exactly that cycle, then advance; go to DONE if last element, else ISSUE.
  - A response arriving in the same cycle as its request handshake is not accepted. Earliest response is the cycle after.
- DONE: done = 1 for one cycle, then IDLE. busy = 1 in ISSUE, WAIT_RSP and DONE.
- Advance rule: elem_idx += 1, and the next address is computed as:
  - unit stride: addr += 1 << eew
  - constant stride: addr += stride
  - indexed: addr = base_addr + zero-extended idx_offset for the new elem_idx
  - All address arithmetic is modulo 2^XLEN; wrap-around is silent.
- Byte lanes: lane = addr[1:0] aligned down to the element size.
  - mem_be = (1 << (1 << eew)) - 1, shifted left by lane.
  - mem_wdata = low element bits of vs_rdata replicated across all lanes.
  - vd_wdata = mem_rdata shifted right by lane*8, masked to the element width.
- Protocol violations:
  - mem_rsp_valid outside WAIT_RSP is ignored.
  - start while busy is ignored; latched config is unchanged.
- Reset asserted mid-operation returns immediately to IDLE with all outputs 0; any outstanding response is dropped.

Optional Feature:
VEC_LSU_MISALIGN_EN
- Defined:
  - Adds output `misalign` (1 bit, reset 0).
  - If the address in ISSUE is not aligned to the element size, no request is issued (mem_req_valid stays 0) and the sequencer goes to DONE.
  - `misalign` pulses together with `done`.
- Undefined: the port is absent; misaligned addresses are issued as-is, with lane computed from the aligned-down address.

Decomposition:
- Shared package (vector_processor_defs): state enum `lsu_state_e`, eew encoding enum `eew_e`, and the element-byte-count function.
- Sub-module `vec_lsu_addr_gen`: combinational next-address, byte-enable and lane-shift logic. The FSM, counters and handshake stay in the top.

Test Plan:
- Unit-stride load, base=0x1000, eew=10, vl=4, ready always 1, response 1 cycle later → addrs 0x1000/04/08/0C; mem_be=1111; 4 vd_wr_en pulses; done in the cycle after the last write.
- Strided store, base=0x2000, stride=0x10, eew=00, vl=3, vs_rdata=0xAB, ready low for 2 cycles on element 1 → addrs 0x2000/10/20; mem_be=0001; request held stable while stalled; mem_wdata=0xABABABAB; 3 handshakes then done.
- Indexed load, base=0x100, offsets {8,0,0x20}, eew=01 → addrs 0x108, 0x100, 0x120; mem_be 0011/0011/0011; vd_wdata = low 16 bits of mem_rdata.
- vl=0 start → no mem_req_valid; done one cycle after start; busy high for exactly one cycle.
- Reset low during WAIT_RSP of element 2 of vl=8 → outputs 0 immediately; a later mem_rsp_valid produces no vd_wr_en; a new start works normally.
- With VEC_LSU_MISALIGN_EN: eew=10, base=0x1002 → no request; misalign and done pulse together.

Source files
------------

// File: rtl/vec_lsu_sequencer_pkg.sv
// Shared definitions for the vector load/store sequencer: FSM states, element-width
// encoding and the element byte-count helper.
package vector_processor_defs;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ISSUE    = 2'b01,
        WAIT_RSP = 2'b10,
        DONE     = 2'b11
    } lsu_state_e;

    typedef enum logic [1:0] {
        EEW_8   = 2'b00,
        EEW_16  = 2'b01,
        EEW_32  = 2'b10,
        EEW_RSV = 2'b11
    } eew_e;

    // The reserved encoding behaves as a 32-bit element.
    function automatic logic [3:0] elem_bytes(input eew_e eew);
        case (eew)
            EEW_8:   return 4'd1;
            EEW_16:  return 4'd2;
            default: return 4'd4;
        endcase
    endfunction

endpackage

// File: rtl/vec_lsu_sequencer_addr_gen.sv
// Combinational address, byte-lane and data-steering logic for vec_lsu_sequencer.
// Optional VEC_LSU_MISALIGN_EN adds the misaligned-address flag.
module vec_lsu_addr_gen
    import vector_processor_defs::*;
#(
    parameter int XLEN  = 32,
    parameter int IDX_W = 32
) (
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   base,
    input  logic [XLEN-1:0]   stride,
    input  logic [IDX_W-1:0]  idx_offset,
    input  eew_e              eew,
    input  logic              unit_stride,
    input  logic              indexed,
    input  logic [XLEN-1:0]   st_data,
    input  logic [XLEN-1:0]   ld_data,
    output logic [XLEN-1:0]   cur_addr,
    output logic [XLEN-1:0]   next_addr,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
`ifdef VEC_LSU_MISALIGN_EN
    ,
    output logic              misaligned
`endif
);

    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);

    logic [3:0]      eb;
    logic [LW-1:0]   lane;
    logic [NB-1:0]   be_base;
    logic [XLEN-1:0] shifted;

    assign eb = elem_bytes(eew);

    // Indexed addresses track the offset of the current element directly, so the
    // address register only carries the unit/constant-stride walk.
    assign cur_addr  = indexed ? base + XLEN'(idx_offset) : addr;
    assign next_addr = unit_stride ? addr + XLEN'(eb) : addr + stride;

    assign lane    = cur_addr[LW-1:0] & ~(eb[LW-1:0] - LW'(1));
    assign shifted = ld_data >> {lane, 3'b000};
    assign be      = be_base << lane;

    always_comb begin
        be_base = '0;
        wdata   = '0;
        rdata   = '0;
        for (int b = 0; b < NB; b++) begin
            be_base[b]     = (b < int'(eb));
            wdata[b*8 +: 8] = st_data[(b % int'(eb))*8 +: 8];
            rdata[b*8 +: 8] = (b < int'(eb)) ? shifted[b*8 +: 8] : 8'h00;
        end
    end

`ifdef VEC_LSU_MISALIGN_EN
    assign misaligned = |(cur_addr[LW-1:0] & (eb[LW-1:0] - LW'(1)));
`endif

endmodule

// File: rtl/vec_lsu_sequencer.sv
// Element-by-element vector load/store sequencer (unit, constant-stride, indexed).
// Optional VEC_LSU_MISALIGN_EN aborts on misaligned element addresses.
module vec_lsu_sequencer
    import vector_processor_defs::*;
#(
    parameter int XLEN  = 32,
    parameter int VL_W  = 9,
    parameter int IDX_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              ld_inst,
    input  logic              st_inst,
    input  logic              stride_sel,
    input  logic              index_str,
    input  logic [1:0]        eew,
    input  logic [XLEN-1:0]   base_addr,
    input  logic [XLEN-1:0]   stride,
    input  logic [VL_W-1:0]   vl,
    input  logic [IDX_W-1:0]  idx_offset,
    input  logic [XLEN-1:0]   vs_rdata,
    output logic [VL_W-1:0]   elem_idx,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              vd_wr_en,
    output logic [XLEN-1:0]   vd_wdata,
    output logic              busy,
    output logic              done
`ifdef VEC_LSU_MISALIGN_EN
    ,
    output logic              misalign
`endif
);

    lsu_state_e      state_q, state_d;
    logic [VL_W-1:0] elem_idx_q, elem_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            st_q, index_q, unit_q;
    eew_e            eew_q;
    logic [XLEN-1:0] base_q, stride_q;
    logic [VL_W-1:0] vl_q;

    logic            load_cfg, req_valid, wr_en, last, issue_blk;
    logic [XLEN-1:0] cur_addr, next_addr, wdata, rdata;
    logic [XLEN/8-1:0] be;

    vec_lsu_addr_gen #(.XLEN(XLEN), .IDX_W(IDX_W)) u_addr_gen (
        .addr        (addr_q),
        .base        (base_q),
        .stride      (stride_q),
        .idx_offset  (idx_offset),
        .eew         (eew_q),
        .unit_stride (unit_q),
        .indexed     (index_q),
        .st_data     (vs_rdata),
        .ld_data     (mem_rdata),
        .cur_addr    (cur_addr),
        .next_addr   (next_addr),
        .be          (be),
        .wdata       (wdata),
        .rdata       (rdata)
`ifdef VEC_LSU_MISALIGN_EN
        ,
        .misaligned  (issue_blk)
`endif
    );

`ifndef VEC_LSU_MISALIGN_EN
    assign issue_blk = 1'b0;
`endif

    assign last = (elem_idx_q == vl_q - VL_W'(1));

    always_comb begin
        state_d   = state_q;
        elem_d    = elem_idx_q;
        addr_d    = addr_q;
        load_cfg  = 1'b0;
        req_valid = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (ld_inst || st_inst)) begin
                    load_cfg = 1'b1;
                    elem_d   = '0;
                    addr_d   = base_addr;
                    state_d  = (vl == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issue_blk) begin
                    state_d = DONE;
                end else begin
                    req_valid = 1'b1;
                    if (mem_req_ready) begin
                        if (st_q) begin
                            elem_d  = elem_idx_q + VL_W'(1);
                            addr_d  = next_addr;
                            state_d = last ? DONE : ISSUE;
                        end else begin
                            state_d = WAIT_RSP;
                        end
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    wr_en   = 1'b1;
                    elem_d  = elem_idx_q + VL_W'(1);
                    addr_d  = next_addr;
                    state_d = last ? DONE : ISSUE;
                end
            end
            DONE: begin
                state_d = IDLE;
                elem_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            elem_idx_q <= '0;
            addr_q     <= '0;
            st_q       <= 1'b0;
            index_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            elem_idx_q <= elem_d;
            addr_q     <= addr_d;
            if (load_cfg) begin
                st_q    <= st_inst;
                index_q <= index_str;
            end
        end
    end

    // Configuration payload is only ever read while busy, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_cfg) begin
            unit_q   <= stride_sel;
            eew_q    <= eew_e'(eew);
            base_q   <= base_addr;
            stride_q <= stride;
            vl_q     <= vl;
        end
    end

`ifdef VEC_LSU_MISALIGN_EN
    logic mis_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mis_q <= 1'b0;
        else        mis_q <= (state_q == ISSUE) && issue_blk;
    end
    assign misalign = mis_q;
`endif

    assign elem_idx      = elem_idx_q;
    assign mem_req_valid = req_valid;
    assign mem_addr      = cur_addr;
    assign mem_we        = (state_q == ISSUE) && st_q;
    assign mem_be        = (state_q == ISSUE) ? be : '0;
    assign mem_wdata     = ((state_q == ISSUE) && st_q) ? wdata : '0;
    assign vd_wr_en      = wr_en;
    assign vd_wdata      = wr_en ? rdata : '0;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

endmodule

// File: tb/tb_vec_lsu_sequencer.sv
// Directed plus randomized bench for vec_lsu_sequencer against an arithmetic reference
// model of element addresses, byte lanes and data steering.
module tb_vec_lsu_sequencer;

    localparam int XLEN  = 32;
    localparam int VL_W  = 9;
    localparam int IDX_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              start, ld_inst, st_inst, stride_sel, index_str;
    logic [1:0]        eew;
    logic [XLEN-1:0]   base_addr, stride;
    logic [VL_W-1:0]   vl;
    logic [IDX_W-1:0]  idx_offset;
    logic [XLEN-1:0]   vs_rdata;
    logic [VL_W-1:0]   elem_idx;
    logic              mem_req_valid, mem_req_ready;
    logic [XLEN-1:0]   mem_addr;
    logic              mem_we;
    logic [XLEN/8-1:0] mem_be;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rdata;
    logic              vd_wr_en;
    logic [XLEN-1:0]   vd_wdata;
    logic              busy, done;
`ifdef VEC_LSU_MISALIGN_EN
    logic              misalign;
`endif

    logic [31:0] idx_tab [16];
    logic [31:0] st_tab  [16];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Register-file model: offset and store element follow elem_idx combinationally.
    always_comb begin
        idx_offset = (elem_idx < 9'd16) ? idx_tab[elem_idx[3:0]] : '0;
        vs_rdata   = (elem_idx < 9'd16) ? st_tab[elem_idx[3:0]]  : '0;
    end

    vec_lsu_sequencer #(.XLEN(XLEN), .VL_W(VL_W), .IDX_W(IDX_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .ld_inst       (ld_inst),
        .st_inst       (st_inst),
        .stride_sel    (stride_sel),
        .index_str     (index_str),
        .eew           (eew),
        .base_addr     (base_addr),
        .stride        (stride),
        .vl            (vl),
        .idx_offset    (idx_offset),
        .vs_rdata      (vs_rdata),
        .elem_idx      (elem_idx),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .vd_wr_en      (vd_wr_en),
        .vd_wdata      (vd_wdata),
        .busy          (busy),
`ifdef VEC_LSU_MISALIGN_EN
        .misalign      (misalign),
`endif
        .done          (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ebytes(input logic [1:0] e);
        return (e == 2'd0) ? 1 : (e == 2'd1) ? 2 : 4;
    endfunction

    function automatic int lane_of(input logic [31:0] a, input int eb);
        return (int'(a[1:0]) / eb) * eb;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input int eb);
        return 4'(((1 << eb) - 1) << lane_of(a, eb));
    endfunction

    function automatic logic [31:0] emask(input int eb);
        return (eb == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * eb)) - 1);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input int eb);
        logic [31:0] el;
        el = d & emask(eb);
        return (eb == 1) ? el * 32'h0101_0101 : (eb == 2) ? el * 32'h0001_0001 : el;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] d, input logic [31:0] a, input int eb);
        return (d >> (8 * lane_of(a, eb))) & emask(eb);
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, mem_req_valid, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_idx"}, elem_idx, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_be"}, mem_be, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_vdwr"}, vd_wr_en, 0);
        check({tag, "_vdwdata"}, vd_wdata, 0);
    endtask

    task automatic run_op(input bit is_st, input bit unit, input bit idx, input logic [1:0] e,
                          input logic [31:0] base, input logic [31:0] strd, input int n,
                          input int max_stall, input int stall_el, input int stall_n,
                          input int max_lat, input int abort_at);
        int eb, stalls, lat;
        logic [31:0] a, rd;
        eb = ebytes(e);
        @(negedge clk);
        start = 1'b1; ld_inst = !is_st; st_inst = is_st; stride_sel = unit; index_str = idx;
        eew = e; base_addr = base; stride = strd; vl = VL_W'(n);
        #1 check("start_idle_busy", busy, 0);
        @(negedge clk);
        start = 1'b0; ld_inst = 1'b0; st_inst = 1'b0;
        base_addr = $urandom; stride = $urandom; vl = VL_W'($urandom_range(20, 1));
        eew = 2'($urandom_range(3, 0)); stride_sel = $urandom_range(1, 0) == 1;
        index_str = $urandom_range(1, 0) == 1;
        for (int i = 0; i < n; i++) begin
            a = idx ? base + idx_tab[i] : unit ? base + 32'(i * eb) : base + strd * 32'(i);
            stalls = (i == stall_el) ? stall_n : $urandom_range(max_stall, 0);
            for (int s = 0; s < stalls; s++) begin
                mem_req_ready = 1'b0;
                mem_rsp_valid = $urandom_range(1, 0) == 1;
                start = $urandom_range(1, 0) == 1;
                ld_inst = 1'b1;
                #1;
                check("stall_valid", mem_req_valid, 1);
                check("stall_addr", mem_addr, a);
                check("stall_be", mem_be, model_be(a, eb));
                check("stall_we", mem_we, is_st);
                check("stall_vdwr", vd_wr_en, 0);
                @(negedge clk);
            end
            start = 1'b0; ld_inst = 1'b0;
            mem_req_ready = 1'b1;
            mem_rsp_valid = !is_st && ($urandom_range(1, 0) == 1);
            #1;
            check("req_valid", mem_req_valid, 1);
            check("req_addr", mem_addr, a);
            check("req_be", mem_be, model_be(a, eb));
            check("req_we", mem_we, is_st);
            check("req_elem_idx", elem_idx, i);
            check("req_busy", busy, 1);
            check("req_vdwr", vd_wr_en, 0);
            if (is_st) check("req_wdata", mem_wdata, model_wdata(st_tab[i], eb));
            @(negedge clk);
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
            if (i == abort_at) begin
                reset = 1'b0;
                #1 check_quiet("abort");
                @(negedge clk);
                reset = 1'b1;
                mem_rsp_valid = 1'b1; mem_rdata = $urandom;
                #1;
                check("abort_rsp_vdwr", vd_wr_en, 0);
                check("abort_rsp_busy", busy, 0);
                @(negedge clk);
                mem_rsp_valid = 1'b0;
                return;
            end
            if (!is_st) begin
                lat = $urandom_range(max_lat, 0);
                for (int w = 0; w < lat; w++) begin
                    #1;
                    check("rsp_wait_valid", mem_req_valid, 0);
                    check("rsp_wait_vdwr", vd_wr_en, 0);
                    @(negedge clk);
                end
                rd = $urandom;
                mem_rsp_valid = 1'b1; mem_rdata = rd;
                #1;
                check("rsp_vdwr", vd_wr_en, 1);
                check("rsp_vdwdata", vd_wdata, model_rdata(rd, a, eb));
                @(negedge clk);
                mem_rsp_valid = 1'b0;
            end
        end
        #1;
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_valid", mem_req_valid, 0);
        @(negedge clk);
        #1;
        check("after_done", done, 0);
        check("after_busy", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int eb, mode;
        logic [31:0] b, s;
        reset = 1'b0; start = 1'b0; ld_inst = 1'b0; st_inst = 1'b0; stride_sel = 1'b0;
        index_str = 1'b0; eew = 2'd0; base_addr = '0; stride = '0; vl = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        for (int k = 0; k < 16; k++) begin idx_tab[k] = '0; st_tab[k] = '0; end
        repeat (2) @(negedge clk);
        #1 check_quiet("reset");
        @(negedge clk);
        reset = 1'b1;

        // Start without a load/store opcode is ignored.
        @(negedge clk);
        start = 1'b1; vl = 9'd3;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("nop_start_busy", busy, 0);
        check("nop_start_valid", mem_req_valid, 0);

        run_op(0, 1, 0, 2'b10, 32'h1000, 32'h0, 4, 0, -1, 0, 0, -1);

        for (int k = 0; k < 16; k++) st_tab[k] = 32'h1234_56AB;
        run_op(1, 0, 0, 2'b00, 32'h2000, 32'h10, 3, 0, 1, 2, 0, -1);

        idx_tab[0] = 32'h8; idx_tab[1] = 32'h0; idx_tab[2] = 32'h20;
        run_op(0, 0, 1, 2'b01, 32'h100, 32'h0, 3, 1, -1, 0, 2, -1);

        run_op(0, 1, 0, 2'b10, 32'h3000, 32'h0, 0, 0, -1, 0, 0, -1);

        run_op(0, 1, 0, 2'b10, 32'h4000, 32'h0, 8, 0, -1, 0, 1, 2);
        run_op(0, 1, 0, 2'b00, 32'h5001, 32'h0, 5, 1, -1, 0, 1, -1);

        run_op(1, 1, 0, 2'b01, 32'hFFFF_FFFC, 32'h0, 4, 1, -1, 0, 0, -1);

`ifdef VEC_LSU_MISALIGN_EN
        @(negedge clk);
        start = 1'b1; ld_inst = 1'b1; stride_sel = 1'b1; index_str = 1'b0; eew = 2'b10;
        base_addr = 32'h1002; vl = 9'd4;
        @(negedge clk);
        start = 1'b0; ld_inst = 1'b0; mem_req_ready = 1'b1;
        #1 check("mis_no_req", mem_req_valid, 0);
        @(negedge clk);
        #1;
        check("mis_done", done, 1);
        check("mis_flag", misalign, 1);
        check("mis_no_req2", mem_req_valid, 0);
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        check("mis_done_clr", done, 0);
        check("mis_flag_clr", misalign, 0);
`else
        run_op(0, 1, 0, 2'b10, 32'h1002, 32'h0, 4, 0, -1, 0, 1, -1);
`endif

        for (int t = 0; t < 24; t++) begin
            eew  = 2'($urandom_range(3, 0));
            eb   = ebytes(eew);
            mode = $urandom_range(2, 0);
            b = $urandom & ~32'(eb - 1);
            s = $urandom & ~32'(eb - 1);
            for (int k = 0; k < 16; k++) begin
                idx_tab[k] = $urandom_range(255, 0) & ~32'(eb - 1);
                st_tab[k]  = $urandom;
            end
            run_op($urandom_range(1, 0) == 1, mode == 1, mode == 2, eew, b, s,
                   $urandom_range(8, 1), 2, -1, 0, 2, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
